sram_arb2: RTL and testbench

Two-port arbiter that shares one single-port SRAM (`sp_sram_wbe4`, 1-cycle read latency) between the AHB interface (port 0) and a secondary on-chip requester (port 1, e.g. DMA or init engine). Each cycle it grants at most one request and drives the SRAM control bus. It routes read data back to the port that issued the read. Port 0 has fixed priority, and a wait counter bounds port-1 starvation.

---
 rtl/sram_arb2.sv | 122 ++++++++++++
 tb/tb_sram_arb2.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_arb2.sv
// Two-port arbiter sharing one single-port SRAM with 1-cycle read latency.
// Port 0 has fixed priority; a wait counter bounds how long port 1 can be starved.
module sram_arb2 #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_BITS  = 10,
    parameter int MAX_WAIT   = 4
) (
    input  logic                  hclk_i,
    input  logic                  hrst_n_i,
    input  logic                  req0_i,
    input  logic                  req1_i,
    input  logic                  we0_i,
    input  logic                  we1_i,
    input  logic [3:0]            wbe0_i,
    input  logic [3:0]            wbe1_i,
    input  logic [ADDR_BITS-1:0]  addr0_i,
    input  logic [ADDR_BITS-1:0]  addr1_i,
    input  logic [DATA_WIDTH-1:0] wdata0_i,
    input  logic [DATA_WIDTH-1:0] wdata1_i,
    output logic                  gnt0_o,
    output logic                  gnt1_o,
    output logic                  rvalid0_o,
    output logic                  rvalid1_o,
    output logic [DATA_WIDTH-1:0] rdata0_o,
    output logic [DATA_WIDTH-1:0] rdata1_o,
    output logic                  mem_en_o,
    output logic                  mem_we_o,
    output logic [3:0]            mem_wbe_o,
    output logic [ADDR_BITS-1:0]  mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i,
    output logic [15:0]           conflict_cnt_o
);

    localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

    logic [3:0]  wait_cnt_reg, wait_cnt_next;
    logic        rd_pend_reg, rd_pend_next;
    logic        rd_id_reg, rd_id_next;
    logic [15:0] conflict_cnt_reg, conflict_cnt_next;
    logic        gnt0, gnt1;
    logic [1:0]  rvalid_vec;

    // Grants are forced low while reset is held, even with requests present.
    always_comb begin
        gnt1 = hrst_n_i & req1_i & (~req0_i | (wait_cnt_reg == MAX_WAIT_C));
        gnt0 = hrst_n_i & req0_i & ~gnt1;
    end

    assign gnt0_o = gnt0;
    assign gnt1_o = gnt1;

    always_comb begin
        mem_en_o    = gnt0 | gnt1;
        mem_we_o    = 1'b0;
        mem_wbe_o   = 4'h0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        if (gnt0) begin
            mem_we_o    = we0_i;
            mem_wbe_o   = we0_i ? wbe0_i : 4'h0;
            mem_addr_o  = addr0_i;
            mem_wdata_o = wdata0_i;
        end else if (gnt1) begin
            mem_we_o    = we1_i;
            mem_wbe_o   = we1_i ? wbe1_i : 4'h0;
            mem_addr_o  = addr1_i;
            mem_wdata_o = wdata1_i;
        end
    end

    always_comb begin
        wait_cnt_next     = wait_cnt_reg;
        rd_pend_next      = 1'b0;
        rd_id_next        = rd_id_reg;
        conflict_cnt_next = conflict_cnt_reg;

        if (!req1_i || gnt1) begin
            wait_cnt_next = 4'h0;
        end else if (wait_cnt_reg != MAX_WAIT_C) begin
            wait_cnt_next = wait_cnt_reg + 4'd1;
        end

        // Only a granted read leaves a pending return; writes and idle cycles clear it.
        if (gnt0 || gnt1) begin
            rd_pend_next = ~mem_we_o;
            rd_id_next   = gnt1;
        end

        if (req0_i && req1_i && (conflict_cnt_reg != 16'hFFFF)) begin
            conflict_cnt_next = conflict_cnt_reg + 16'd1;
        end
    end

    always_ff @(posedge hclk_i or negedge hrst_n_i) begin
        if (!hrst_n_i) begin
            wait_cnt_reg     <= 4'h0;
            rd_pend_reg      <= 1'b0;
            rd_id_reg        <= 1'b0;
            conflict_cnt_reg <= 16'h0000;
        end else begin
            wait_cnt_reg     <= wait_cnt_next;
            rd_pend_reg      <= rd_pend_next;
            rd_id_reg        <= rd_id_next;
            conflict_cnt_reg <= conflict_cnt_next;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_rvalid
            assign rvalid_vec[gi] = rd_pend_reg & (rd_id_reg == 1'(gi));
        end
    endgenerate

    assign rvalid0_o      = rvalid_vec[0];
    assign rvalid1_o      = rvalid_vec[1];
    assign rdata0_o       = hrst_n_i ? mem_rdata_i : '0;
    assign rdata1_o       = hrst_n_i ? mem_rdata_i : '0;
    assign conflict_cnt_o = conflict_cnt_reg;

endmodule

// File: tb/tb_sram_arb2.sv
// Scoreboard bench for sram_arb2: a behavioural arbiter/memory model predicts grants and
// read returns; a separate monitor checks every rvalid against the expected-read queue.
module tb_sram_arb2;

    localparam int MAX_WAIT = 4;

    typedef struct {
        bit          v;
        bit          we;
        logic [3:0]  wbe;
        logic [9:0]  addr;
        logic [31:0] wdata;
    } req_t;

    typedef struct {
        bit          port;
        logic [31:0] data;
        int          due;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0, req1, we0, we1;
    logic [3:0]  wbe0, wbe1;
    logic [9:0]  addr0, addr1;
    logic [31:0] wdata0, wdata1;
    logic        gnt0, gnt1, rvalid0, rvalid1;
    logic [31:0] rdata0, rdata1;
    logic        mem_en, mem_we;
    logic [3:0]  mem_wbe;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic [15:0] conflict_cnt;

    logic [31:0] sram   [0:1023];
    logic [31:0] refmem [0:1023];

    exp_t   q[$];
    req_t   p0, p1;
    int     n_checks = 0;
    int     n_pass   = 0;
    int     ncnt     = 0;
    int     streak   = 0;
    int     conf     = 0;
    logic   dut_g0, dut_g1;

    always #5 clk = ~clk;

    sram_arb2 #(.DATA_WIDTH(32), .ADDR_BITS(10), .MAX_WAIT(MAX_WAIT)) dut (
        .hclk_i(clk), .hrst_n_i(rst_n),
        .req0_i(req0), .req1_i(req1), .we0_i(we0), .we1_i(we1),
        .wbe0_i(wbe0), .wbe1_i(wbe1), .addr0_i(addr0), .addr1_i(addr1),
        .wdata0_i(wdata0), .wdata1_i(wdata1),
        .gnt0_o(gnt0), .gnt1_o(gnt1), .rvalid0_o(rvalid0), .rvalid1_o(rvalid1),
        .rdata0_o(rdata0), .rdata1_o(rdata1),
        .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_wbe_o(mem_wbe),
        .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata),
        .conflict_cnt_o(conflict_cnt)
    );

    // Single-port SRAM with byte-enabled writes and 1-cycle read latency.
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                for (int b = 0; b < 4; b++)
                    if (mem_wbe[b]) sram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
            end else begin
                mem_rdata <= sram[mem_addr];
            end
        end
    end

    task automatic check(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Monitor: pops the expected-read queue whenever the DUT returns read data.
    always @(negedge clk) begin
        exp_t e;
        ncnt++;
        if (rvalid0 && rvalid1) check(1'b0, "rvalid_both", 64'd3, 64'd0);
        if (rvalid0 || rvalid1) begin
            if (q.size() == 0) begin
                check(1'b0, "unexpected_rvalid", {rvalid1, rvalid0}, 64'd0);
            end else begin
                e = q.pop_front();
                check(ncnt == e.due, "rvalid_latency", ncnt, e.due);
                check(rvalid1 == e.port, "rvalid_port", rvalid1, e.port);
                check((e.port ? rdata1 : rdata0) == e.data, "rdata", e.port ? rdata1 : rdata0, e.data);
                $display("read return: port %0d data %08h", e.port, e.data);
            end
        end else if (q.size() > 0 && q[0].due <= ncnt) begin
            e = q.pop_front();
            check(1'b0, "missing_rvalid", 64'd0, {63'd0, 1'b1});
        end
    end

    function automatic req_t mk(input bit we, input logic [9:0] a, input logic [31:0] d, input logic [3:0] be);
        req_t r;
        r.v = 1'b1; r.we = we; r.addr = a; r.wdata = d; r.wbe = be;
        return r;
    endfunction

    function automatic req_t rnd_req();
        logic [9:0] a;
        a = ($urandom_range(0, 7) == 0) ? 10'h3FF : 10'($urandom_range(0, 15));
        return mk(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom));
    endfunction

    // One bus cycle: entered at posedge+1, drives pending requests, checks, advances model.
    task automatic do_cycle();
        bit   e0, e1;
        req_t g;
        req0 = p0.v; we0 = p0.we; wbe0 = p0.wbe; addr0 = p0.addr; wdata0 = p0.wdata;
        req1 = p1.v; we1 = p1.we; wbe1 = p1.wbe; addr1 = p1.addr; wdata1 = p1.wdata;
        #1;
        e1 = rst_n && p1.v && (!p0.v || streak >= MAX_WAIT);
        e0 = rst_n && p0.v && !e1;
        dut_g0 = gnt0;
        dut_g1 = gnt1;
        check(gnt0 == e0, "gnt0", gnt0, e0);
        check(gnt1 == e1, "gnt1", gnt1, e1);
        check(mem_en == (e0 | e1), "mem_en", mem_en, e0 | e1);
        check(conflict_cnt == 16'(conf), "conflict_cnt", conflict_cnt, conf);
        if (e0 || e1) begin
            g = e1 ? p1 : p0;
            check(mem_we == g.we, "mem_we", mem_we, g.we);
            check(mem_wbe == (g.we ? g.wbe : 4'h0), "mem_wbe", mem_wbe, g.we ? g.wbe : 4'h0);
            check(mem_addr == g.addr, "mem_addr", mem_addr, g.addr);
            check(mem_wdata == g.wdata, "mem_wdata", mem_wdata, g.wdata);
            if (g.we) begin
                for (int b = 0; b < 4; b++)
                    if (g.wbe[b]) refmem[g.addr][8*b +: 8] = g.wdata[8*b +: 8];
                $display("grant port %0d write addr %03h data %08h wbe %h", e1, g.addr, g.wdata, g.wbe);
            end else begin
                q.push_back('{port: e1, data: refmem[g.addr], due: ncnt + 2});
                $display("grant port %0d read  addr %03h expect %08h", e1, g.addr, refmem[g.addr]);
            end
        end else begin
            check({mem_we, mem_wbe, mem_addr, mem_wdata} == '0, "mem_idle",
                  {mem_we, mem_wbe, mem_addr, mem_wdata}, 64'd0);
        end
        if (!rst_n) begin
            check({rvalid0, rvalid1, rdata0, rdata1} == '0, "reset_outputs",
                  {rvalid0, rvalid1, rdata0}, 64'd0);
        end else begin
            if (p0.v && p1.v && conf != 16'hFFFF) conf++;
            streak = (p1.v && !e1) ? streak + 1 : 0;
        end
        if (e0) p0.v = 1'b0;
        if (e1) p1.v = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int guard = 0;
        while ((p0.v || p1.v) && guard < 50) begin
            do_cycle();
            guard++;
        end
        repeat (2) do_cycle();
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) begin
            sram[i]   = 32'h0;
            refmem[i] = 32'h0;
        end
        p0 = mk(1'b0, 10'h0, 32'h0, 4'h0); p0.v = 1'b0;
        p1 = p0;
        rst_n = 1'b0;
        @(posedge clk);
        #1;

        // Reset held with both ports requesting: nothing may be granted.
        p0 = mk(1'b0, 10'h1, 32'h0, 4'h0);
        p1 = mk(1'b0, 10'h2, 32'h0, 4'h0);
        repeat (2) do_cycle();
        rst_n = 1'b1;
        do_cycle();
        check(dut_g0 == 1'b1, "release_gnt0", dut_g0, 1);
        drain();

        // Port 0 write then read-back.
        p0 = mk(1'b1, 10'h005, 32'hDEADBEEF, 4'hF); do_cycle();
        p0 = mk(1'b0, 10'h005, 32'h0, 4'h0);        do_cycle();
        drain();

        // Port 1 partial-byte write over all-ones.
        p1 = mk(1'b1, 10'h3FF, 32'hFFFFFFFF, 4'hF);   do_cycle();
        p1 = mk(1'b1, 10'h3FF, 32'h11223344, 4'b0101); do_cycle();
        p1 = mk(1'b0, 10'h3FF, 32'h0, 4'h0);          do_cycle();
        check(refmem[10'h3FF] == 32'hFF22FF44, "model_bytes", refmem[10'h3FF], 32'hFF22FF44);
        drain();

        // Interleaved reads on alternating ports.
        p0 = mk(1'b1, 10'h001, 32'hA5A5_0001, 4'hF); do_cycle();
        p1 = mk(1'b1, 10'h002, 32'h5A5A_0002, 4'hF); do_cycle();
        p0 = mk(1'b0, 10'h001, 32'h0, 4'h0);         do_cycle();
        p1 = mk(1'b0, 10'h002, 32'h0, 4'h0);         do_cycle();
        drain();

        // Starvation bound: grant pattern 0,0,0,0,1 with both ports always requesting.
        for (int i = 0; i < 10; i++) begin
            if (!p0.v) p0 = mk(1'b0, 10'($urandom_range(0, 15)), 32'h0, 4'h0);
            if (!p1.v) p1 = mk(1'b0, 10'($urandom_range(0, 15)), 32'h0, 4'h0);
            do_cycle();
            check(dut_g1 == ((i % 5) == 4), "starve_pattern", dut_g1, (i % 5) == 4);
        end
        drain();

        // Reset in the cycle after a read grant cancels the return.
        p0 = mk(1'b0, 10'h001, 32'h0, 4'h0);
        p1 = mk(1'b0, 10'h002, 32'h0, 4'h0);
        do_cycle();
        p0 = mk(1'b0, 10'h001, 32'h0, 4'h0);
        do_cycle();
        rst_n = 1'b0;
        q.delete();
        conf = 0; streak = 0; p0.v = 1'b0; p1.v = 1'b0;
        do_cycle();
        rst_n = 1'b1;
        do_cycle();
        check({dut_g0, dut_g1} == 2'b00, "idle_after_reset", {dut_g0, dut_g1}, 0);
        for (int i = 0; i < 5; i++) begin
            if (!p0.v) p0 = mk(1'b0, 10'h003, 32'h0, 4'h0);
            if (!p1.v) p1 = mk(1'b0, 10'h004, 32'h0, 4'h0);
            do_cycle();
            check(dut_g1 == (i == 4), "wait_cleared", dut_g1, i == 4);
        end
        drain();

        // Randomized traffic with requests held until granted.
        for (int i = 0; i < 400; i++) begin
            if (!p0.v && $urandom_range(0, 2) != 0) p0 = rnd_req();
            if (!p1.v && $urandom_range(0, 2) != 0) p1 = rnd_req();
            do_cycle();
        end
        drain();
        check(q.size() == 0, "queue_drained", q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
